// File: rtl/ew_mem_pkg.sv
// Shared definitions for the E/W memory bank: default geometry and the
// access-type decode used by ew_mem_bank.
package ew_mem_pkg;

  localparam int EW_MEM_WIDTH = 8;
  localparam int EW_MEM_DEPTH = 4;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  // E gates the access; W picks write over read.
  function automatic acc_e ew_decode(input logic e, input logic w);
    acc_e acc;
    if (e == 1'b0) begin
      acc = ACC_IDLE;
    end else if (w == 1'b1) begin
      acc = ACC_WRITE;
    end else begin
      acc = ACC_READ;
    end
    return acc;
  endfunction

endpackage

// File: rtl/ew_mem_word.sv
// One storage word of the bank together with its written-since-reset flag.
// Synchronous clear dominates the write enable.
module ew_mem_word
  import ew_mem_pkg::*;
#(
  parameter int WIDTH = EW_MEM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic [WIDTH-1:0] data_r;
  logic             vld_r;

  // Word storage: clear on reset, capture and mark valid on write, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {WIDTH{1'b0}};
      vld_r  <= 1'b0;
    end else if (we) begin
      data_r <= d;
      vld_r  <= 1'b1;
    end else begin
      data_r <= data_r;
      vld_r  <= vld_r;
    end
  end

  assign q   = data_r;
  assign vld = vld_r;

endmodule

// File: rtl/ew_mem_bank.sv
// DEPTH x WIDTH storage bank behind a single enable/write interface.
// Reads are registered (one-cycle latency) and report whether the word
// addressed had ever been written since reset.
// Optional build macro EW_MEM_HOLD_EN: O is forced to zero on idle and
// write cycles instead of holding the last read value.
module ew_mem_bank
  import ew_mem_pkg::*;
#(
  parameter  int WIDTH = EW_MEM_WIDTH,
  parameter  int DEPTH = EW_MEM_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             E,
  input  logic             W,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             OV,
  output logic             RERR
);

  acc_e             acc_s;
  logic [DEPTH-1:0] we_s;
  logic [WIDTH-1:0] word_q_s [DEPTH];
  logic [DEPTH-1:0] word_vld_s;
  logic [WIDTH-1:0] rd_data_s;
  logic             rd_vld_s;

  logic [WIDTH-1:0] o_r;
  logic             ov_r;
  logic             rerr_r;

  // Classify this cycle's access from E and W.
  always_comb begin
    acc_s = ew_decode(E, W);
  end

  // One-hot write enable: only the addressed word captures on a write.
  always_comb begin
    we_s = {DEPTH{1'b0}};
    if (acc_s == ACC_WRITE) begin
      we_s[A] = 1'b1;
    end else begin
      we_s = {DEPTH{1'b0}};
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    ew_mem_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk(CLK),
      .rst(RST),
      .we (we_s[i]),
      .d  (D),
      .q  (word_q_s[i]),
      .vld(word_vld_s[i])
    );
  end

  // Read mux: select the addressed word and its valid flag.
  always_comb begin
    rd_data_s = word_q_s[A];
    rd_vld_s  = word_vld_s[A];
  end

  // Output register: reads load O/OV/RERR, idles drop OV, writes leave status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      o_r    <= {WIDTH{1'b0}};
      ov_r   <= 1'b0;
      rerr_r <= 1'b0;
    end else begin
      case (acc_s)
        ACC_READ: begin
          o_r    <= rd_data_s;
          ov_r   <= 1'b1;
          rerr_r <= ~rd_vld_s;
        end
        ACC_WRITE: begin
`ifdef EW_MEM_HOLD_EN
          o_r    <= {WIDTH{1'b0}};
`else
          o_r    <= o_r;
`endif
          ov_r   <= ov_r;
          rerr_r <= rerr_r;
        end
        ACC_IDLE: begin
`ifdef EW_MEM_HOLD_EN
          o_r    <= {WIDTH{1'b0}};
`else
          o_r    <= o_r;
`endif
          ov_r   <= 1'b0;
          rerr_r <= rerr_r;
        end
        default: begin
          o_r    <= o_r;
          ov_r   <= 1'b0;
          rerr_r <= rerr_r;
        end
      endcase
    end
  end

  assign O    = o_r;
  assign OV   = ov_r;
  assign RERR = rerr_r;

endmodule

// File: tb/tb_ew_mem_bank.sv
// Self-checking bench for ew_mem_bank: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_ew_mem_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             E;
  logic             W;
  logic [AW-1:0]    A;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] O;
  logic             OV;
  logic             RERR;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_vld [DEPTH];
  logic [WIDTH-1:0] m_o;
  bit               m_ov;
  bit               m_rerr;

  ew_mem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .E   (E),
    .W   (W),
    .A   (A),
    .D   (D),
    .O   (O),
    .OV  (OV),
    .RERR(RERR)
  );

  always #5 CLK = ~CLK;

  // Apply one cycle of stimulus, advance the model, sample 1 unit after the edge.
  task automatic cyc(input bit rst, input bit e, input bit w, input int a, input logic [7:0] d);
    RST = rst; E = e; W = w; A = a[AW-1:0]; D = d;
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = 8'h00;
        m_vld[i] = 1'b0;
      end
      m_o = 8'h00; m_ov = 1'b0; m_rerr = 1'b0;
    end else if (e && w) begin
      m_mem[a] = d;
      m_vld[a] = 1'b1;
`ifdef EW_MEM_HOLD_EN
      m_o = 8'h00;
`endif
    end else if (e) begin
      m_o    = m_mem[a];
      m_ov   = 1'b1;
      m_rerr = !m_vld[a];
    end else begin
      m_ov = 1'b0;
`ifdef EW_MEM_HOLD_EN
      m_o = 8'h00;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 0, 8'hFF);
    cyc(1, 1, 1, 0, 8'hFF);
    tests_run++;
    if (O !== 8'h00 || OV !== 1'b0 || RERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got O=%h OV=%b RERR=%b, want O=00 OV=0 RERR=0", O, OV, RERR);
    end
    cyc(0, 1, 0, 0, 8'h00);
    tests_run++;
    if (O !== 8'h00 || OV !== 1'b1 || RERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_read: got O=%h OV=%b RERR=%b, want O=00 OV=1 RERR=1", O, OV, RERR);
    end
  endtask

  task automatic test_write_read();
    cyc(0, 1, 1, 2, 8'hA5);
    cyc(0, 1, 0, 2, 8'h00);
    tests_run++;
    if (O !== 8'hA5 || OV !== 1'b1 || RERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_read: got O=%h OV=%b RERR=%b, want O=a5 OV=1 RERR=0", O, OV, RERR);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, i, 8'h10 + 8'(i));
    for (int i = DEPTH - 1; i >= 0; i--) begin
      cyc(0, 1, 0, i, 8'h00);
      exp = 8'h10 + 8'(i);
      tests_run++;
      if (O !== exp || OV !== 1'b1 || RERR !== 1'b0) begin
        tests_failed++;
        $display("FAIL sweep_a%0d: got O=%h OV=%b RERR=%b, want O=%h OV=1 RERR=0", i, O, OV, RERR, exp);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [7:0] exp;
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 1, 8'h3C);
    cyc(0, 1, 0, 1, 8'h00);
    tests_run++;
    if (O !== 8'h00 || OV !== 1'b1 || RERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL gate_write_ignored: got O=%h OV=%b RERR=%b, want O=00 OV=1 RERR=1", O, OV, RERR);
    end
    cyc(0, 1, 1, 2, 8'hC3);
    cyc(0, 1, 0, 2, 8'h00);
    cyc(0, 0, 0, 2, 8'h00);
`ifdef EW_MEM_HOLD_EN
    exp = 8'h00;
`else
    exp = 8'hC3;
`endif
    tests_run++;
    if (O !== exp || OV !== 1'b0 || RERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold: got O=%h OV=%b RERR=%b, want O=%h OV=0 RERR=0", O, OV, RERR, exp);
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 1, 0, 8'h77);
    cyc(1, 1, 0, 0, 8'h00);
    tests_run++;
    if (O !== 8'h00 || OV !== 1'b0 || RERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got O=%h OV=%b RERR=%b, want O=00 OV=0 RERR=0", O, OV, RERR);
    end
    cyc(0, 1, 0, 0, 8'h00);
    tests_run++;
    if (O !== 8'h00 || OV !== 1'b1 || RERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_read: got O=%h OV=%b RERR=%b, want O=00 OV=1 RERR=1", O, OV, RERR);
    end
  endtask

  task automatic test_ew_sequence();
    cyc(0, 0, 0, 0, 8'h5A);
    cyc(0, 0, 1, 0, 8'h5A);
    cyc(0, 1, 0, 0, 8'h5A);
    tests_run++;
    if (O !== 8'h00 || OV !== 1'b1 || RERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL seq_read_empty: got O=%h OV=%b RERR=%b, want O=00 OV=1 RERR=1", O, OV, RERR);
    end
    cyc(0, 1, 1, 0, 8'h5A);
    tests_run++;
    if (OV !== 1'b1 || RERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL seq_write_status: got OV=%b RERR=%b, want OV=1 RERR=1", OV, RERR);
    end
    cyc(0, 0, 0, 0, 8'h5A);
    cyc(0, 1, 0, 0, 8'h00);
    tests_run++;
    if (O !== 8'h5A || OV !== 1'b1 || RERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_readback: got O=%h OV=%b RERR=%b, want O=5a OV=1 RERR=0", O, OV, RERR);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
      tests_run++;
      if (O !== m_o || OV !== m_ov || RERR !== m_rerr) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: got O=%h OV=%b RERR=%b, want O=%h OV=%b RERR=%b",
                   n, O, OV, RERR, m_o, m_ov, m_rerr);
      end
    end
  endtask

  initial begin
    RST = 1'b1; E = 1'b0; W = 1'b0; A = '0; D = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 8'h00;
      m_vld[i] = 1'b0;
    end
    m_o = 8'h00; m_ov = 1'b0; m_rerr = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid();
    test_ew_sequence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ew_mem_bank.md
# ew_mem_bank

Parametrised successor to the single-bit E/W storage cell: a DEPTH x WIDTH synchronous storage bank with chip enable (E), write (W), registered read data and per-word valid tracking. It sits in the lab datapath wherever several stored words are needed behind one enable/write interface. It also flags reads of never-written words.

## Interface
- WIDTH, 8: data word width in bits (>=1)
- DEPTH, 4: number of words (>=2, power of two)
- AW, $clog2(DEPTH): address width (derived, not overridden)
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- E  in  1  enable; no access occurs when 0
- W  in  1  write select when E=1 (1 = write, 0 = read)
- A  in  AW  word address
- D  in  WIDTH  write data
- O  out  WIDTH  registered read data
- OV  out  1  O holds data from a completed read this cycle
- RERR  out  1  last completed read targeted a never-written word

## Operation
- Access decode per edge: E=0 -> idle; E=1,W=0 -> read A; E=1,W=1 -> write D to A.
- Write: mem[A] <= D, valid[A] <= 1. O, OV, RERR unchanged by a write.
- Read: O <= mem[A], OV <= 1, RERR <= ~valid[A]. Unwritten words read as 0 (cleared at reset).
- Idle: OV <= 0; O and RERR hold last value.
- Address is always in range (DEPTH power of two); no wrap logic needed.
- Bank holds one access per cycle; read and write are mutually exclusive by W.
- Reset (any time, incl. mid-sequence): all mem words <= 0, all valid <= 0, O <= 0, OV <= 0, RERR <= 0. RST dominates E/W in the same edge; access presented with RST is discarded.

## Timing
- Write latency: data visible to a read issued on the next cycle (read at edge N+1 returns D written at edge N).
- Read latency: 1 cycle; O/OV/RERR valid after the edge that samples the read.
- Back-to-back reads: one result per cycle, OV stays 1.
- E, W, A, D sampled only at rising CLK; no combinational path from inputs to outputs.
- Reset values: O=0, OV=0, RERR=0.

## Configuration
- EW_MEM_HOLD_EN defined: idle cycles and writes force O <= 0 instead of holding (O is 0 whenever OV=0); RERR still holds.
- Not defined: O holds last read value through idle and write cycles (default).

## Structure
- Package ew_mem_pkg: default WIDTH/DEPTH constants, access-type enum (IDLE, READ, WRITE) used by the decode.
- Sub-module ew_mem_word: one WIDTH-bit word plus its valid bit, with sync clear and write-enable; ew_mem_bank instantiates DEPTH of them and muxes the read.
- Decode and output register live in ew_mem_bank.

## Test plan
- Reset: RST=1 two cycles with E=1,W=1,A=0,D=8'hFF -> O=0, OV=0, RERR=0; subsequent read of A=0 returns 8'h00 with RERR=1.
- Write then read: write 8'hA5 to A=2, read A=2 next cycle -> O=8'hA5, OV=1, RERR=0 one cycle later.
- All-words sweep: write 8'h10+i to A=i for i=0..3, then reads A=3..0 back-to-back -> O=8'h13,12,11,10 on consecutive cycles, OV=1 throughout.
- Enable gating: E=0,W=1,A=1,D=8'h3C, then read A=1 -> O=8'h00, RERR=1 (write ignored); an idle cycle drops OV to 0 and O holds (O=0 with EW_MEM_HOLD_EN).
- Reset mid-operation: write 8'h77 to A=0, assert RST one cycle during a read of A=0 -> O=0, OV=0; later read of A=0 returns 8'h00 with RERR=1.
- Input sequence 00,01,10,11,00 on (E,W) at A=0, D=8'h5A, 10-time-unit steps -> only the 11 step writes; following read returns 8'h5A, OV=1, RERR=0.
